// File: rtl/cpu_ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ram_arb_pkg
// Description : Shared definitions for the two-master CPU/RAM arbiter.
//               Holds the default RAM geometry, the master-id type and the
//               command record that is steered from the winning master to
//               the RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ram_arb_pkg;

    localparam int c_DEFAULT_ADDR_W = 10;   // 1024-word RAM
    localparam int c_DEFAULT_DATA_W = 32;
    localparam int c_DEFAULT_BE_W   = c_DEFAULT_DATA_W / 8;

    // One bit is enough to name either of the two masters.
    typedef logic master_id_t;

    localparam master_id_t c_M0 = 1'b0;
    localparam master_id_t c_M1 = 1'b1;

    // Command presented to the RAM by whichever master holds the grant.
    typedef struct packed {
        logic [c_DEFAULT_ADDR_W-1:0] address;
        logic                        write;
        logic [c_DEFAULT_DATA_W-1:0] writedata;
        logic [c_DEFAULT_BE_W-1:0]   byteenable;
    } ram_cmd_t;

    // A master is requesting when it asserts either strobe; read+write
    // together is treated as a write by the command builder.
    function automatic logic is_request(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ram_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ram_rr_pick
// Description : Two-way round-robin grant selection, purely combinational.
//               A lone requester always wins; under contention the master
//               that did not win last time is picked.
// Ports       : i_req0/i_req1  - request from master 0 / master 1
//               i_last_grant   - id of the master granted most recently
//               o_valid        - some master is granted this cycle
//               o_grant        - id of the granted master (valid w/ o_valid)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_ram_rr_pick
    import cpu_ram_arb_pkg::*;
(
    input  logic       i_req0,
    input  logic       i_req1,
    input  master_id_t i_last_grant,
    output logic       o_valid,
    output master_id_t o_grant
);

    always_comb begin
        o_valid = i_req0 | i_req1;
        o_grant = c_M0;
        if (i_req0 && i_req1) begin
            o_grant = ~i_last_grant;
        end else if (i_req1) begin
            o_grant = c_M1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ram_arbiter
// Description : Arbitrates two bus masters onto one single-port synchronous
//               RAM. One transaction is accepted per cycle with zero added
//               latency; contention is resolved round-robin. Reads return one
//               cycle after acceptance through a single pending-read register.
// Ports       : clk, reset_n            - clock, async active-low reset
//               m0_*/m1_*               - master ports (address, read, write,
//                                         writedata, byteenable, waitrequest,
//                                         readdata, readdatavalid)
//               ram_*                   - RAM port (address, chipselect,
//                                         write, writedata, byteenable,
//                                         readdata)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_ram_arbiter
    import cpu_ram_arb_pkg::*;
#(
    parameter int ADDR_W   = c_DEFAULT_ADDR_W,
    parameter int DATA_W   = c_DEFAULT_DATA_W,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   ram_address,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic [DATA_W/8-1:0] ram_byteenable,
    input  logic [DATA_W-1:0]   ram_readdata
);

    localparam int c_HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(MAX_HOLD);

    // The command record is sized from the package defaults.
    if ((ADDR_W != c_DEFAULT_ADDR_W) || (DATA_W != c_DEFAULT_DATA_W)) begin : g_width_check
        $error("cpu_ram_arbiter: ADDR_W/DATA_W must match cpu_ram_arb_pkg defaults");
    end

    logic                r_last_grant;
    logic                r_pend_valid;
    master_id_t          r_pend_id;
    logic [c_HOLD_W-1:0] r_hold_cnt;

    logic       w_req0;
    logic       w_req1;
    logic       w_valid;
    master_id_t w_grant;
    logic       w_other_req;
    ram_cmd_t   w_cmd0;
    ram_cmd_t   w_cmd1;
    ram_cmd_t   w_cmd_sel;

    assign w_req0 = is_request(m0_read, m0_write);
    assign w_req1 = is_request(m1_read, m1_write);

    cpu_ram_rr_pick u_rr_pick (
        .i_req0       (w_req0),
        .i_req1       (w_req1),
        .i_last_grant (r_last_grant),
        .o_valid      (w_valid),
        .o_grant      (w_grant)
    );

    // Build both candidate commands and steer the winner to the RAM.
    // The write strobe alone decides direction, so read+write is a write.
    always_comb begin
        w_cmd0            = '0;
        w_cmd0.address    = m0_address;
        w_cmd0.write      = m0_write;
        w_cmd0.writedata  = m0_writedata;
        w_cmd0.byteenable = m0_byteenable;

        w_cmd1            = '0;
        w_cmd1.address    = m1_address;
        w_cmd1.write      = m1_write;
        w_cmd1.writedata  = m1_writedata;
        w_cmd1.byteenable = m1_byteenable;

        w_cmd_sel = (w_grant == c_M1) ? w_cmd1 : w_cmd0;
    end

    assign ram_chipselect = w_valid;
    assign ram_write      = w_valid & w_cmd_sel.write;
    assign ram_address    = w_cmd_sel.address;
    assign ram_writedata  = w_cmd_sel.writedata;
    assign ram_byteenable = w_cmd_sel.byteenable;

    // Only a master that asks and loses is stalled.
    assign m0_waitrequest = w_req0 & ~(w_valid & (w_grant == c_M0));
    assign m1_waitrequest = w_req1 & ~(w_valid & (w_grant == c_M1));

    // Read data is broadcast; only the strobe identifies the owner.
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m0_readdatavalid = r_pend_valid & (r_pend_id == c_M0);
    assign m1_readdatavalid = r_pend_valid & (r_pend_id == c_M1);

    assign w_other_req = (w_grant == c_M0) ? w_req1 : w_req0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= c_M0;
            r_pend_valid <= 1'b0;
            r_pend_id    <= c_M0;
            r_hold_cnt   <= '0;
        end else begin
            // Pending-read register refills every cycle, so back-to-back
            // reads from either master stream without bubbles.
            r_pend_valid <= w_valid & ~w_cmd_sel.write;
            if (w_valid) begin
                r_last_grant <= w_grant;
                r_pend_id    <= w_grant;
            end

            // Consecutive wins by one master while the other waits.
            if (!w_valid || !w_other_req || (w_grant != r_last_grant)) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt != c_HOLD_MAX) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    // Round-robin alone bounds starvation: a stalled master that keeps its
    // request up is served on the very next cycle, and no master can build
    // up MAX_HOLD back-to-back wins against a waiting peer.
    a_m0_served_next: assert property (@(posedge clk) disable iff (!reset_n)
        m0_waitrequest |=> !m0_waitrequest);
    a_m1_served_next: assert property (@(posedge clk) disable iff (!reset_n)
        m1_waitrequest |=> !m1_waitrequest);
    a_hold_bound: assert property (@(posedge clk) disable iff (!reset_n)
        r_hold_cnt < c_HOLD_MAX);

endmodule
`default_nettype wire

// File: tb/tb_cpu_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_ram_arbiter
// Description : Self-checking bench for cpu_ram_arbiter. A behavioural RAM
//               sits on the RAM port; a shadow memory plus a small grant and
//               read-return model predict every master-visible output.
//               Directed scenarios are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_ram_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int N_RAND = 400;

    logic clk;
    logic reset_n;

    logic [ADDR_W-1:0] m_addr  [2];
    logic              m_rd    [2];
    logic              m_wr    [2];
    logic [DATA_W-1:0] m_wdata [2];
    logic [BE_W-1:0]   m_be    [2];

    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_chipselect, ram_write;
    logic [DATA_W-1:0] ram_writedata;
    logic [BE_W-1:0]   ram_byteenable;
    logic [DATA_W-1:0] ram_readdata;

    cpu_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m_addr[0]),
        .m0_read          (m_rd[0]),
        .m0_write         (m_wr[0]),
        .m0_writedata     (m_wdata[0]),
        .m0_byteenable    (m_be[0]),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m_addr[1]),
        .m1_read          (m_rd[1]),
        .m1_write         (m_wr[1]),
        .m1_writedata     (m_wdata[1]),
        .m1_byteenable    (m_be[1]),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .ram_address      (ram_address),
        .ram_chipselect   (ram_chipselect),
        .ram_write        (ram_write),
        .ram_writedata    (ram_writedata),
        .ram_byteenable   (ram_byteenable),
        .ram_readdata     (ram_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return (32'h9E3779B9 * i) ^ 32'h5A5A0000;
    endfunction

    // ---------------- behavioural single-port synchronous RAM --------------
    logic [DATA_W-1:0] ram_mem [DEPTH];
    initial begin
        ram_readdata = '0;
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = init_word(i);
    end
    always @(posedge clk) begin
        logic [DATA_W-1:0] merged;
        if (ram_chipselect) begin
            if (ram_write) begin
                merged = ram_mem[ram_address];
                for (int b = 0; b < BE_W; b++)
                    if (ram_byteenable[b]) merged[8*b +: 8] = ram_writedata[8*b +: 8];
                ram_mem[ram_address] <= merged;
            end else begin
                ram_readdata <= ram_mem[ram_address];
            end
        end
    end

    // ---------------- reference model state -------------------------------
    logic [DATA_W-1:0] shadow [DEPTH];
    int                model_last;     // master that won most recently
    bit                exp_pv;         // a read return is due this cycle
    int                exp_pid;
    logic [DATA_W-1:0] exp_pdata;

    int n_checks;
    int n_errors;

    // Observations captured at the last sampling point.
    logic              obs_w0, obs_w1, obs_rdv0, obs_rdv1;
    logic [DATA_W-1:0] obs_rdata0;
    int                rdv_cnt [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input bit r0, input bit r1, input int last);
        if (r0 && r1) return 1 - last;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic set_req(input int n, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        m_rd[n] = rd; m_wr[n] = wr; m_addr[n] = a; m_wdata[n] = d; m_be[n] = be;
    endtask

    task automatic idle_all();
        for (int n = 0; n < 2; n++) set_req(n, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // One bus cycle: sample and check at the falling edge, then advance the
    // model across the rising edge. Returns the model's winner (-1 if none).
    task automatic step(output int g);
        bit r0, r1;
        @(negedge clk);
        r0 = m_rd[0] | m_wr[0];
        r1 = m_rd[1] | m_wr[1];
        g  = pick(r0, r1, model_last);

        obs_w0 = m0_waitrequest;   obs_w1 = m1_waitrequest;
        obs_rdv0 = m0_readdatavalid; obs_rdv1 = m1_readdatavalid;
        obs_rdata0 = m0_readdata;
        if (obs_rdv0 === 1'b1) rdv_cnt[0]++;
        if (obs_rdv1 === 1'b1) rdv_cnt[1]++;

        check_eq("wait0", m0_waitrequest, r0 && g != 0);
        check_eq("wait1", m1_waitrequest, r1 && g != 1);
        check_eq("chipselect", ram_chipselect, g >= 0);
        if (g >= 0) begin
            check_eq("ram_write", ram_write, m_wr[g]);
            check_eq("ram_address", ram_address, m_addr[g]);
            if (m_wr[g]) begin
                check_eq("ram_writedata", ram_writedata, m_wdata[g]);
                check_eq("ram_byteenable", ram_byteenable, m_be[g]);
            end
        end else begin
            check_eq("ram_write_idle", ram_write, 1'b0);
        end
        check_eq("rdv0", m0_readdatavalid, exp_pv && exp_pid == 0);
        check_eq("rdv1", m1_readdatavalid, exp_pv && exp_pid == 1);
        if (exp_pv) begin
            check_eq("readdata0", m0_readdata, exp_pdata);
            check_eq("readdata1", m1_readdata, exp_pdata);
        end

        exp_pv = 1'b0;
        if (g >= 0) begin
            if (m_wr[g]) begin
                for (int b = 0; b < BE_W; b++)
                    if (m_be[g][b]) shadow[m_addr[g]][8*b +: 8] = m_wdata[g][8*b +: 8];
            end else begin
                exp_pv    = 1'b1;
                exp_pid   = g;
                exp_pdata = shadow[m_addr[g]];
            end
            model_last = g;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_all();
        exp_pv = 1'b0;
        model_last = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_rdv0", m0_readdatavalid, 1'b0);
        check_eq("reset_rdv1", m1_readdatavalid, 1'b0);
        check_eq("reset_wait0", m0_waitrequest, 1'b0);
        check_eq("reset_wait1", m1_waitrequest, 1'b0);
        check_eq("reset_cs", ram_chipselect, 1'b0);
        reset_n = 1'b1;
    endtask

    // Masters hold a stalled request; accepted or idle masters get new work.
    task automatic refresh_masters(input int g);
        for (int n = 0; n < 2; n++) begin
            if (!(m_rd[n] | m_wr[n]) || g == n) begin
                if ($urandom_range(0, 3) != 0) begin
                    int k;
                    logic [ADDR_W-1:0] a;
                    k = $urandom_range(0, 3);
                    a = ($urandom_range(0, 7) == 0) ? ADDR_W'(10'h3FF) : ADDR_W'($urandom_range(0, 15));
                    set_req(n, k != 2, k >= 2, a, $urandom, BE_W'($urandom_range(0, 15)));
                end else begin
                    set_req(n, 1'b0, 1'b0, '0, '0, '0);
                end
            end
        end
    endtask

    initial begin
        int g;
        int waits;
        n_checks = 0;
        n_errors = 0;
        rdv_cnt[0] = 0; rdv_cnt[1] = 0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
        do_reset();

        // Write then read back at 0x0A5 from m0.
        set_req(0, 1'b0, 1'b1, 10'h0A5, 32'hDEADBEEF, 4'hF);
        step(g);
        set_req(0, 1'b1, 1'b0, 10'h0A5, '0, '0);
        step(g);
        idle_all();
        step(g);
        check_eq("wr_rd_0a5_rdv0", obs_rdv0, 1'b1);
        check_eq("wr_rd_0a5_data", obs_rdata0, 32'hDEADBEEF);

        // Constant contention after reset: m1, m0, m1, ...
        do_reset();
        rdv_cnt[0] = 0; rdv_cnt[1] = 0;
        set_req(0, 1'b1, 1'b0, 10'h001, '0, '0);
        set_req(1, 1'b1, 1'b0, 10'h002, '0, '0);
        for (int i = 0; i < 8; i++) begin
            step(g);
            // The loser is the one stalled: m0 waits on even cycles.
            check_eq("rr_m0_wait", obs_w0, (i % 2) == 0);
            check_eq("rr_m1_wait", obs_w1, (i % 2) == 1);
        end
        idle_all();
        step(g);
        check_eq("rr_rdv_count_m0", rdv_cnt[0], 4);
        check_eq("rr_rdv_count_m1", rdv_cnt[1], 4);

        // Partial write from m1 at the top address.
        set_req(1, 1'b0, 1'b1, 10'h3FF, 32'hFFFFFFFF, 4'hF);
        step(g);
        set_req(1, 1'b0, 1'b1, 10'h3FF, 32'h12345678, 4'h3);
        step(g);
        set_req(1, 1'b1, 1'b0, 10'h3FF, '0, '0);
        step(g);
        idle_all();
        step(g);
        check_eq("be_merge_rdv1", obs_rdv1, 1'b1);
        check_eq("be_merge_data", obs_rdata0, 32'hFFFF5678);

        // Lone reader streams without stalls.
        rdv_cnt[0] = 0; rdv_cnt[1] = 0;
        waits = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1'b1, 1'b0, ADDR_W'(i + 32), '0, '0);
            step(g);
            if (obs_w0 === 1'b1) waits++;
        end
        idle_all();
        step(g);
        check_eq("solo_wait_cycles", waits, 0);
        check_eq("solo_rdv_count", rdv_cnt[0], 6);

        // Reset lands right after a read is accepted.
        set_req(0, 1'b1, 1'b0, 10'h010, '0, '0);
        step(g);
        reset_n = 1'b0;
        idle_all();
        exp_pv = 1'b0;
        model_last = 0;
        #1;
        check_eq("rst_drop_rdv0_async", m0_readdatavalid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(g);
        check_eq("rst_drop_rdv0", obs_rdv0, 1'b0);
        check_eq("rst_drop_rdv1", obs_rdv1, 1'b0);
        set_req(0, 1'b1, 1'b0, 10'h011, '0, '0);
        set_req(1, 1'b1, 1'b0, 10'h012, '0, '0);
        step(g);
        check_eq("rst_last_grant_m0_waits", obs_w0, 1'b1);
        idle_all();
        step(g);

        // Randomized mixed traffic.
        for (int i = 0; i < N_RAND; i++) begin
            refresh_masters(g);
            step(g);
        end
        idle_all();
        step(g);
        step(g);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete within its time budget");
        $fatal(1);
    end

endmodule
`default_nettype wire
